// File: rtl/reg_map_responder.sv
// Register-map responder: decodes single-cycle bus requests onto a bank of RW config
// and RO status word registers, answering each accepted request with a one-cycle ready.
module reg_map_responder #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           NUM_REGS   = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [255:0]          RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0,
  parameter int unsigned           RD_WAIT    = 0
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_bus_req,
  input  logic                           i_bus_req_is_wr,
  input  logic [ADDR_WIDTH-1:0]          i_bus_addr,
  input  logic [DATA_WIDTH-1:0]          i_bus_wr_data,
  input  logic [DATA_WIDTH-1:0]          i_bus_wr_biten,
  output logic                           o_bus_ready,
  output logic [DATA_WIDTH-1:0]          o_bus_rd_data,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] i_hw_status,
  output logic [NUM_REGS*DATA_WIDTH-1:0] o_cfg_q,
  output logic [NUM_REGS-1:0]            o_cfg_wr_strb,
  output logic                           o_decode_err,
  output logic                           o_overlap_err
);

  localparam int unsigned IdxW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] RangeBytes = ADDR_WIDTH'(NUM_REGS * 4);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e                r_state;
  logic [2:0]            r_wcnt;
  logic [DATA_WIDTH-1:0] r_rd_hold;
  logic                  r_hold_err;
  logic [DATA_WIDTH-1:0] r_cfg [NUM_REGS];

  logic [ADDR_WIDTH-1:0] w_off;
  logic                  w_in_range;
  logic [IdxW-1:0]       w_idx;
  logic [DATA_WIDTH-1:0] w_rd_val;

  // Addresses below BASE_ADDR wrap to a huge offset and fall out of range.
  assign w_off      = i_bus_addr - BASE_ADDR;
  assign w_in_range = (w_off < RangeBytes);
  assign w_idx      = w_off[IdxW+1:2];

  always_comb begin
    w_rd_val = '0;
    if (w_in_range) begin
      if (RO_MASK[w_idx]) w_rd_val = i_hw_status[w_idx*DATA_WIDTH +: DATA_WIDTH];
      else                w_rd_val = r_cfg[w_idx];
    end
  end

  always_comb begin
    o_cfg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!RO_MASK[i]) o_cfg_q[i*DATA_WIDTH +: DATA_WIDTH] = r_cfg[i];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_wcnt        <= '0;
      r_rd_hold     <= '0;
      r_hold_err    <= 1'b0;
      o_bus_ready   <= 1'b0;
      o_bus_rd_data <= '0;
      o_decode_err  <= 1'b0;
      o_overlap_err <= 1'b0;
      o_cfg_wr_strb <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_cfg[i] <= RST_VAL;
    end else begin
      o_bus_ready   <= 1'b0;
      o_decode_err  <= 1'b0;
      o_cfg_wr_strb <= '0;
      unique case (r_state)
        StIdle: begin
          if (i_bus_req) begin
            if (i_bus_req_is_wr) begin
              o_bus_ready   <= 1'b1;
              o_bus_rd_data <= '0;
              o_decode_err  <= !w_in_range;
              for (int i = 0; i < NUM_REGS; i++) begin
                if (w_in_range && !RO_MASK[i] && (w_idx == IdxW'(i))) begin
                  r_cfg[i]         <= (r_cfg[i] & ~i_bus_wr_biten) |
                                      (i_bus_wr_data & i_bus_wr_biten);
                  o_cfg_wr_strb[i] <= 1'b1;
                end
              end
            end else if (RD_WAIT == 0) begin
              o_bus_ready   <= 1'b1;
              o_bus_rd_data <= w_rd_val;
              o_decode_err  <= !w_in_range;
            end else begin
              // Sample now; presented when the wait count runs out.
              r_rd_hold  <= w_rd_val;
              r_hold_err <= !w_in_range;
              r_wcnt     <= 3'(RD_WAIT);
              r_state    <= StWait;
            end
          end
        end
        StWait: begin
          if (i_bus_req) o_overlap_err <= 1'b1;
          r_wcnt <= r_wcnt - 3'd1;
          if (r_wcnt == 3'd1) begin
            o_bus_ready   <= 1'b1;
            o_bus_rd_data <= r_rd_hold;
            o_decode_err  <= r_hold_err;
            r_state       <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_map_responder.sv
// Directed bench: instance A uses RD_WAIT=0 with regs 2/3 read-only; instance B uses RD_WAIT=3.
module tb_reg_map_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A
  logic         a_rst, a_req, a_wr;
  logic [31:0]  a_addr, a_wdata, a_biten, a_rdata;
  logic         a_ready, a_derr, a_oerr;
  logic [255:0] a_status, a_cfg, a_exp_cfg;
  logic [7:0]   a_strb;

  // Instance B
  logic         b_rst, b_req, b_wr;
  logic [31:0]  b_addr, b_wdata, b_biten, b_rdata;
  logic         b_ready, b_derr, b_oerr;
  logic [255:0] b_status, b_cfg, b_exp_cfg;
  logic [7:0]   b_strb;

  reg_map_responder #(
    .RO_MASK (256'h0C),
    .RD_WAIT (0)
  ) u_dut_a (
    .i_clk           (clk),
    .i_rst           (a_rst),
    .i_bus_req       (a_req),
    .i_bus_req_is_wr (a_wr),
    .i_bus_addr      (a_addr),
    .i_bus_wr_data   (a_wdata),
    .i_bus_wr_biten  (a_biten),
    .o_bus_ready     (a_ready),
    .o_bus_rd_data   (a_rdata),
    .i_hw_status     (a_status),
    .o_cfg_q         (a_cfg),
    .o_cfg_wr_strb   (a_strb),
    .o_decode_err    (a_derr),
    .o_overlap_err   (a_oerr)
  );

  reg_map_responder #(
    .RO_MASK (256'h0),
    .RD_WAIT (3)
  ) u_dut_b (
    .i_clk           (clk),
    .i_rst           (b_rst),
    .i_bus_req       (b_req),
    .i_bus_req_is_wr (b_wr),
    .i_bus_addr      (b_addr),
    .i_bus_wr_data   (b_wdata),
    .i_bus_wr_biten  (b_biten),
    .o_bus_ready     (b_ready),
    .o_bus_rd_data   (b_rdata),
    .i_hw_status     (b_status),
    .o_cfg_q         (b_cfg),
    .o_cfg_wr_strb   (b_strb),
    .o_decode_err    (b_derr),
    .o_overlap_err   (b_oerr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request on A in the current cycle; return in the ack cycle.
  task automatic a_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] d,
                        input logic [31:0] be);
    a_req = 1'b1; a_wr = wr; a_addr = addr; a_wdata = d; a_biten = be;
    step();
    a_req = 1'b0;
  endtask

  task automatic a_read(input string tag, input logic [31:0] addr, input logic [31:0] exp,
                        input logic exp_err);
    a_xfer(1'b0, addr, 32'h0, 32'h0);
    chk({tag, "_ready"}, a_ready, 1'b1);
    chk({tag, "_data"}, a_rdata, exp);
    chk({tag, "_derr"}, a_derr, exp_err);
  endtask

  task automatic a_write(input string tag, input logic [31:0] addr, input logic [31:0] d,
                         input logic [31:0] be, input logic [7:0] exp_strb,
                         input logic exp_err);
    a_xfer(1'b1, addr, d, be);
    chk({tag, "_ready"}, a_ready, 1'b1);
    chk({tag, "_strb"}, a_strb, exp_strb);
    chk({tag, "_derr"}, a_derr, exp_err);
    chk({tag, "_rdata0"}, a_rdata, 32'h0);
  endtask

  initial begin
    a_rst = 1'b1; a_req = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0; a_biten = '0;
    b_rst = 1'b1; b_req = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0; b_biten = '0;
    a_status = '0;
    for (int i = 0; i < 8; i++) a_status[i*32 +: 32] = 32'hDEAD_0000 | 32'(i);
    a_status[2*32 +: 32] = 32'hCAFE_0002;
    a_status[3*32 +: 32] = 32'hCAFE_0003;
    b_status = '1;
    a_exp_cfg = '0;
    b_exp_cfg = '0;

    step();
    step();
    chk("rst_ready", a_ready, 1'b0);
    chk("rst_rdata", a_rdata, 32'h0);
    chk("rst_derr", a_derr, 1'b0);
    chk("rst_oerr", a_oerr, 1'b0);
    chk("rst_strb", a_strb, 8'h0);
    chk("rst_cfg", a_cfg, a_exp_cfg);
    chk("rst_b_cfg", b_cfg, b_exp_cfg);
    a_rst = 1'b0;
    b_rst = 1'b0;
    step();

    // Read all registers back-to-back; RW read 0, RO read their status slot.
    a_read("rd_r0", 32'h00, 32'h0, 1'b0);
    a_read("rd_r1", 32'h04, 32'h0, 1'b0);
    a_read("rd_r2", 32'h08, 32'hCAFE_0002, 1'b0);
    a_read("rd_r3", 32'h0C, 32'hCAFE_0003, 1'b0);
    a_read("rd_r4", 32'h10, 32'h0, 1'b0);
    a_read("rd_r5", 32'h14, 32'h0, 1'b0);
    a_read("rd_r6", 32'h18, 32'h0, 1'b0);
    a_read("rd_r7", 32'h1C, 32'h0, 1'b0);
    step();
    chk("idle_ready", a_ready, 1'b0);

    // Bit-enable merge on reg 1.
    a_write("be_w1", 32'h04, 32'hFFFF_FFFF, 32'h0000_00FF, 8'h02, 1'b0);
    a_exp_cfg[1*32 +: 32] = 32'h0000_00FF;
    chk("be_cfg1", a_cfg, a_exp_cfg);
    a_write("be_w2", 32'h04, 32'h1234_5678, 32'hFFFF_0000, 8'h02, 1'b0);
    a_exp_cfg[1*32 +: 32] = 32'h1234_00FF;
    chk("be_cfg2", a_cfg, a_exp_cfg);
    step();
    chk("strb_pulse", a_strb, 8'h0);

    // Out-of-range, RO and low-bit-ignored accesses.
    a_write("oor_wr", 32'h20, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 8'h00, 1'b1);
    chk("oor_cfg", a_cfg, a_exp_cfg);
    a_read("oor_rd", 32'h20, 32'h0, 1'b1);
    a_write("ro_wr", 32'h08, 32'h5555_5555, 32'hFFFF_FFFF, 8'h00, 1'b0);
    chk("ro_cfg", a_cfg, a_exp_cfg);
    a_read("ro_rd", 32'h08, 32'hCAFE_0002, 1'b0);
    a_read("lowbits_rd", 32'h07, 32'h1234_00FF, 1'b0);
    a_write("zero_be", 32'h14, 32'hFFFF_FFFF, 32'h0, 8'h20, 1'b0);
    chk("zero_be_cfg", a_cfg, a_exp_cfg);
    step();
    chk("hold_rdata", a_rdata, 32'h0);
    chk("hold_derr", a_derr, 1'b0);

    // Back-to-back writes on B: timing independent of RD_WAIT.
    b_req = 1'b1; b_wr = 1'b1; b_biten = 32'hFFFF_FFFF;
    b_addr = 32'h0; b_wdata = 32'h11;
    step();
    chk("b2b_rdy1", b_ready, 1'b1);
    chk("b2b_strb1", b_strb, 8'h01);
    b_addr = 32'h4; b_wdata = 32'h22;
    step();
    chk("b2b_rdy2", b_ready, 1'b1);
    chk("b2b_strb2", b_strb, 8'h02);
    b_addr = 32'h8; b_wdata = 32'h33;
    step();
    b_req = 1'b0;
    chk("b2b_rdy3", b_ready, 1'b1);
    chk("b2b_strb3", b_strb, 8'h04);
    b_exp_cfg[0*32 +: 32] = 32'h11;
    b_exp_cfg[1*32 +: 32] = 32'h22;
    b_exp_cfg[2*32 +: 32] = 32'h33;
    chk("b2b_cfg", b_cfg, b_exp_cfg);
    step();

    // RD_WAIT=3 read of reg 0 at cycle 0, overlapping request at cycle 2.
    b_req = 1'b1; b_wr = 1'b0; b_addr = 32'h0;
    step();                                    // cycle 1
    b_req = 1'b0;
    chk("w_c1_ready", b_ready, 1'b0);
    step();                                    // cycle 2
    chk("w_c2_ready", b_ready, 1'b0);
    chk("w_c2_oerr", b_oerr, 1'b0);
    b_req = 1'b1; b_addr = 32'h4;
    step();                                    // cycle 3
    b_req = 1'b0;
    chk("w_c3_ready", b_ready, 1'b0);
    chk("w_c3_oerr", b_oerr, 1'b1);
    step();                                    // cycle 4
    chk("w_c4_ready", b_ready, 1'b1);
    chk("w_c4_data", b_rdata, 32'h11);
    b_req = 1'b1; b_addr = 32'h4;
    for (int c = 5; c < 8; c++) begin
      step();
      b_req = 1'b0;
      chk("w2_wait_ready", b_ready, 1'b0);
    end
    step();                                    // cycle 8
    chk("w2_c8_ready", b_ready, 1'b1);
    chk("w2_c8_data", b_rdata, 32'h22);
    chk("w2_oerr_sticky", b_oerr, 1'b1);
    step();

    // Reset mid-read; a write presented during reset must not commit.
    b_req = 1'b1; b_wr = 1'b0; b_addr = 32'h8;
    step();                                    // cycle 1
    b_req = 1'b0;
    step();                                    // cycle 2
    b_rst = 1'b1;
    b_req = 1'b1; b_wr = 1'b1; b_addr = 32'hC; b_wdata = 32'hFFFF; b_biten = 32'hFFFF_FFFF;
    step();                                    // cycle 3
    b_rst = 1'b0;
    b_req = 1'b0;
    chk("mrst_oerr", b_oerr, 1'b0);
    chk("mrst_cfg", b_cfg, 256'h0);
    chk("mrst_ready3", b_ready, 1'b0);
    for (int c = 4; c <= 10; c++) begin
      step();
      chk("mrst_ready", b_ready, 1'b0);
    end
    chk("mrst_strb", b_strb, 8'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
